// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store initiator for a word-wide single-port
// data memory. Sub-word stores are done as read-modify-write. Loads are
// sign- or zero-extended. Misaligned, out-of-range and illegal-funct3
// requests get an error response without touching memory.
module lsu_mem_master #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]  state_q, state_d;
  logic        err_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_bad;

  // Classify a request: out-of-range, misaligned or illegal funct3.
  function automatic logic lsu_err(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr);
    logic e;
    e = (addr >= 32'(MEM_BYTES));
    case (f3)
      F3_B:    e = e;
      F3_H:    e = e | addr[0];
      F3_W:    e = e | (addr[1:0] != 2'b00);
      F3_BU:   e = e | we;
      F3_HU:   e = e | we | addr[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'd0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the captured word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [31:0] w;
    w = word;
    case (f3)
      F3_B: w[8*lane +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) w[31:16] = wdata[15:0];
        else         w[15:0]  = wdata[15:0];
      end
      default: w = wdata;
    endcase
    return w;
  endfunction

  assign accept  = req_valid && (state_q == S_IDLE);
  assign req_bad = lsu_err(req_we, req_funct3, req_addr);

  // Next-state selection for the IDLE/RD/WR/RESP sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)           state_d = S_RESP;
          else if (!req_we)      state_d = S_RD;
          else if (req_funct3 == F3_W) state_d = S_WR;
          else                   state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; async reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) err_q <= req_bad;
    end
  end

  // Request capture and read-data capture; gated onto outputs by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= 32'd0;
    end else if (state_q == S_RD) begin
      word_q  <= mem_RD;
      rdata_q <= we_q ? 32'd0 : load_ext(mem_RD, f3_q, addr_q[1:0]);
    end
  end

  // Outputs decode from state so reset forces them low immediately.
  assign req_ready  = (state_q == S_IDLE);
  assign mem_WE     = (state_q == S_WR);
  assign mem_A      = ((state_q == S_RD) || (state_q == S_WR)) ?
                      {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_WD     = (state_q == S_WR) ?
                      store_merge(word_q, wdata_q, f3_q, addr_q[1:0]) : 32'd0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
  assign resp_err   = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a behavioural
// word-wide memory (synchronous write, combinational read).
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int a_cnt = 0;
  int resp_cnt = 0;
  logic [31:0] last_wa = 32'd0;
  logic [31:0] last_wd = 32'd0;
  logic [31:0] resp_q [$];

  lsu_mem_master #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  assign mem_RD = mem[mem_A[9:2]];

  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[9:2]] <= mem_WD;
  end

  // Activity monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_WE) begin
      we_cnt  <= we_cnt + 1;
      last_wa <= mem_A;
      last_wd <= mem_WD;
    end
    if (mem_A != 32'd0) a_cnt <= a_cnt + 1;
    if (resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      resp_q.push_back(resp_rdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request; checks latency, response data/error, and WE/address activity.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_we);
    int lat;
    int we0;
    int a0;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    we0 = we_cnt;
    a0  = a_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, "_resp1"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_we"}, 32'(we_cnt - we0), 32'(exp_we));
    if (exp_err) check({tag, "_noA"}, 32'(a_cnt - a0), 32'd0);
  endtask

  initial begin
    int n;
    int r0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[7]  = 32'h00000020;
    mem[25] = 32'hCAFEF00D;

    // Reset interrupting an SB in its WR cycle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    r0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'd101; req_wdata = 32'h000000AB;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_WE && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_wr", {31'd0, mem_WE}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_we_drop", {31'd0, mem_WE}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_resp", 32'(resp_cnt - r0), 32'd0);
    check("rst_mem_kept", mem[25], 32'hCAFEF00D);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs", {resp_valid, resp_err, mem_WE, 29'd0}, 32'd0);
    check("rst_A", mem_A, 32'd0);
    check("rst_WD", mem_WD, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);

    // Basic word access.
    txn("lw28", 1'b0, 3'b010, 32'd28, 32'd0, 2, 32'h00000020, 1'b0, 0);
    txn("sw100", 1'b1, 3'b010, 32'd100, 32'h12345678, 2, 32'd0, 1'b0, 1);
    check("sw100_A", last_wa, 32'd100);
    check("sw100_WD", last_wd, 32'h12345678);
    txn("lw100", 1'b0, 3'b010, 32'd100, 32'd0, 2, 32'h12345678, 1'b0, 0);

    // Sub-word store and loads.
    txn("sb101", 1'b1, 3'b000, 32'd101, 32'h000000AB, 3, 32'd0, 1'b0, 1);
    check("sb101_A", last_wa, 32'd100);
    check("sb101_WD", last_wd, 32'h1234AB78);
    check("sb101_mem", mem[25], 32'h1234AB78);
    txn("lb101", 1'b0, 3'b000, 32'd101, 32'd0, 2, 32'hFFFFFFAB, 1'b0, 0);
    txn("lbu101", 1'b0, 3'b100, 32'd101, 32'd0, 2, 32'h000000AB, 1'b0, 0);
    txn("lh102", 1'b0, 3'b001, 32'd102, 32'd0, 2, 32'h00001234, 1'b0, 0);
    txn("sh102", 1'b1, 3'b001, 32'd102, 32'h0000BEEF, 3, 32'd0, 1'b0, 1);
    check("sh102_WD", last_wd, 32'hBEEFAB78);
    txn("lhu102", 1'b0, 3'b101, 32'd102, 32'd0, 2, 32'h0000BEEF, 1'b0, 0);
    txn("lh102s", 1'b0, 3'b001, 32'd102, 32'd0, 2, 32'hFFFFBEEF, 1'b0, 0);

    // Error responses: no memory access.
    txn("e_lw102", 1'b0, 3'b010, 32'd102, 32'd0, 1, 32'd0, 1'b1, 0);
    txn("e_sh103", 1'b1, 3'b001, 32'd103, 32'h0000FFFF, 1, 32'd0, 1'b1, 0);
    txn("e_lb1024", 1'b0, 3'b000, 32'd1024, 32'd0, 1, 32'd0, 1'b1, 0);
    txn("e_f3_011", 1'b0, 3'b011, 32'd28, 32'd0, 1, 32'd0, 1'b1, 0);
    txn("e_sbu", 1'b1, 3'b100, 32'd28, 32'd0, 1, 32'd0, 1'b1, 0);
    check("err_mem", mem[25], 32'hBEEFAB78);

    // Back-to-back with req_valid held high.
    resp_q.delete();
    r0 = resp_cnt;
    n = we_cnt;
    for (int i = 0; i < 3; i++) begin
      int w;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = (i == 1);
      req_funct3 = 3'b010;
      req_addr  = (i == 0) ? 32'd28 : 32'd200;
      req_wdata = 32'hA5A5_0F0F;
      w = 0;
      while (!req_ready && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("b2b_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_resps", 32'(resp_cnt - r0), 32'd3);
    check("b2b_we", 32'(we_cnt - n), 32'd1);
    check("b2b_mem", mem[50], 32'hA5A50F0F);
    if (resp_q.size() == 3) begin
      check("b2b_r0", resp_q[0], 32'h00000020);
      check("b2b_r1", resp_q[1], 32'd0);
      check("b2b_r2", resp_q[2], 32'hA5A50F0F);
    end else begin
      check("b2b_qsize", 32'(resp_q.size()), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
